// File: rtl/mux8way_pkg.sv
// Shared constants and types for the 8-way arbitrated merge.
package mux8way_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_e;
endpackage

// File: rtl/mux8way_arb_rr_pick8.sv
// Rotating-priority search: first requester at or above ptr, modulo 8.
module rr_pick8
  import mux8way_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output sel_t            gnt_idx,
  output logic            gnt_any
);
  sel_t c;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      c = ptr + sel_t'(k);
      if (req[c]) begin
        gnt_idx = c;
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux8way_arb.sv
// 8-to-1 round-robin merge with a one-entry output register.
// MUX8WAY_ARB_PKT_LOCK_EN adds in_last/out_last and holds the grant for a whole packet.
module mux8way_arb
  import mux8way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output sel_t                  out_sel,
  input  logic                  out_ready
`ifdef MUX8WAY_ARB_PKT_LOCK_EN
  ,
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last
`endif
);
  logic             load_en, acc, adv, gnt_any;
  logic [N_CH-1:0]  req;
  sel_t             gnt_idx, ptr_q, ptr_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  sel_t             out_sel_q;

  assign load_en = !out_valid_q || out_ready;
  // Reset gating keeps in_ready low while rst_n is held, regardless of clk.
  assign acc     = rst_n && gnt_any && load_en;

`ifdef MUX8WAY_ARB_PKT_LOCK_EN
  lock_st_e        st_q, st_d;
  sel_t            lock_ch_q, lock_ch_d;
  logic [N_CH-1:0] lock_mask;
  logic            gnt_last, out_last_q;

  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
  end

  assign req      = (st_q == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;
  assign gnt_last = in_last[gnt_idx];
  assign adv      = acc && gnt_last;

  always_comb begin
    st_d      = st_q;
    lock_ch_d = lock_ch_q;
    if (acc) begin
      if (st_q == ST_IDLE && !gnt_last) begin
        st_d      = ST_LOCKED;
        lock_ch_d = gnt_idx;
      end else if (st_q == ST_LOCKED && gnt_last) begin
        st_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      lock_ch_q <= lock_ch_d;
      if (acc) out_last_q <= gnt_last;
    end
  end

  assign out_last = out_last_q;
`else
  assign req = in_valid;
  assign adv = acc;
`endif

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_rdy
    assign in_ready[g] = acc && (gnt_idx == sel_t'(g));
  end

  assign ptr_d = adv ? sel_t'(gnt_idx + sel_t'(1)) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[gnt_idx*WIDTH +: WIDTH];
        out_sel_q   <= gnt_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux8way_arb.sv
// Randomized + directed scoreboard bench for mux8way_arb (honours MUX8WAY_ARB_PKT_LOCK_EN).
module tb_mux8way_arb;
  import mux8way_pkg::*;
  localparam int W = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [7:0]    in_valid = '0, in_last = '0;
  logic [8*W-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic [7:0]    in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  sel_t          out_sel;
`ifdef MUX8WAY_ARB_PKT_LOCK_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  mux8way_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX8WAY_ARB_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q[$];
  beat_t e;
  int checks = 0, failures = 0;
  int m_ptr = 0, m_lch = 0;
  bit m_full = 0, m_lock = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference grant: first valid channel counting up from the pointer, honouring a packet lock.
  function automatic int pick(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (m_ptr + k) % 8;
      if (v[c] && (!m_lock || c == m_lch)) return c;
    end
    return -1;
  endfunction

  // Called right after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int g;
    bit acc;
    logic [7:0] exp_rdy;
    #1;
    chk("out_valid", out_valid, m_full);
    g   = pick(in_valid);
    acc = (g >= 0) && (!m_full || out_ready);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    if (acc) q.push_back('{sel: 3'(g), data: in_data[g*W +: W], last: in_last[g]});
    @(posedge clk);
    if (acc) begin
      m_full = 1;
`ifdef MUX8WAY_ARB_PKT_LOCK_EN
      if (!in_last[g]) begin
        m_lock = 1;
        m_lch  = g;
      end else begin
        m_lock = 0;
        m_ptr  = (g + 1) % 8;
      end
`else
      m_ptr = (g + 1) % 8;
`endif
    end else if (out_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Output monitor: pops the oldest expected beat on every output handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_beat: unexpected beat sel=%0d data=%0h, expected none", out_sel, out_data);
      end else begin
        e = q.pop_front();
        chk("out_sel", out_sel, e.sel);
        chk("out_data", out_data, e.data);
`ifdef MUX8WAY_ARB_PKT_LOCK_EN
        chk("out_last", out_last, e.last);
`endif
      end
    end
  end

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    in_valid = 8'hFF;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 8'h00);
    chk("rst_out_sel", out_sel, 3'd0);
    q.delete();
    m_full = 0; m_ptr = 0; m_lock = 0; m_lch = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = '0;
  endtask

  initial begin
    in_valid = 8'hFF;
    in_last  = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    chk("init_in_ready", in_ready, 8'h00);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_sel", out_sel, 3'd0);
    chk("init_out_data", out_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load: every channel valid, drain every cycle.
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = 16'h0010 + 16'(i);
    in_valid = 8'hFF; out_ready = 1'b1;
    ticks(9);
    in_valid = '0;
    ticks(2);

    // Backpressure on a lone ch5 beat.
    in_data[5*W +: W] = 16'h00A5;
    in_valid = 8'h20; out_ready = 1'b0;
    ticks(3);
    chk("bp_hold_data", out_data, 16'h00A5);
    out_ready = 1'b1; in_valid = '0;
    ticks(2);

    // Pointer wrap from 6: ch7 then ch2.
    in_valid = 8'h84;
    ticks(2);
    in_valid = '0;
    ticks(2);
    chk("wrap_ptr_model", m_ptr, 3);

    // Reset while a beat is held; it must never appear.
    in_valid = 8'h08; out_ready = 1'b0;
    ticks(2);
    in_valid = '0;
    mid_reset();
    out_ready = 1'b1;
    ticks(3);

`ifdef MUX8WAY_ARB_PKT_LOCK_EN
    // Single-beat ch2 packet moves ptr to 3, then a 3-beat ch3 packet beats ch1.
    in_valid = 8'h04; in_last = 8'h04;
    tick();
    in_valid = 8'h0A; in_last = 8'h00;
    ticks(2);
    in_last = 8'h08;
    tick();
    in_last = 8'h02;
    tick();
    in_valid = '0;
    ticks(2);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'($urandom);
      in_valid  = 8'($urandom);
      in_last   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    in_valid = '0; out_ready = 1'b1;
    ticks(4);
    chk("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
